// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    // FSM encodings are visible on the state port, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_LAP_HOLD = 2'd3
    } sw_state_t;

    // 10 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int SYNC_STAGES_DEF     = 2;

    // The tick divider and counters advance in these states.
    function automatic logic is_counting(input sw_state_t s);
        return (s == ST_RUNNING) || (s == ST_LAP_HOLD);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchroniser + debouncer + rising-edge press detector for one raw button.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from stable press to o_press.
// Backpressure: none; o_press is a one-cycle pulse that is never held.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    // A single-flop synchroniser is never safe, so clamp the depth at 2.
    localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int DEB_N    = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int CNT_W    = (DEB_N > 1) ? $clog2(DEB_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

    logic [SYNC_N-1:0] r_sync;
    logic [SYNC_N-1:0] r_sync_vld;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_level;
    logic              r_armed;
    logic              r_press;
    logic              w_sample;
    logic              w_sample_vld;

    assign w_sample     = r_sync[SYNC_N-1];
    assign w_sample_vld = r_sync_vld[SYNC_N-1];
    assign o_press      = r_press;

    // Synchroniser chain, plus a marker that reaches the last stage together
    // with the first real post-reset sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_N-2:0], i_btn};
            r_sync_vld <= {r_sync_vld[SYNC_N-2:0], 1'b1};
        end
    end

    // Debounce: the level flips after DEB_N consecutive samples that disagree
    // with it; any agreeing sample restarts the count. A press pulse fires on
    // the debounced rising edge only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= w_sample;
                r_press <= w_sample & r_armed;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Arm only after a released button has been seen since reset, so a button
    // held through reset release cannot produce a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed <= 1'b0;
        end else if (w_sample_vld && !w_sample && !r_level) begin
            r_armed <= 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM fed by three debounced buttons; lap path only when STOPWATCH_LAP_EN is defined.
// Latency: outputs update on the edge after the cycle a press pulse is high.
// Backpressure: none; events arriving while enable is low are dropped, not queued.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic       master_clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       count_en,
    output logic       clear_pulse,
    output logic       lap_latch,
    output logic       display_frozen,
    output logic [1:0] state
);

    sw_state_t r_state;
    sw_state_t w_state_nxt;
    logic      r_count_en;
    logic      r_clear_pulse;
    logic      w_clear_nxt;
    logic      w_lap_nxt;
    logic      w_ss_raw;
    logic      w_clr_raw;
    logic      w_lap_raw;
    logic      w_ev_clr;
    logic      w_ev_ss;
    logic      w_ev_lap;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_db_start_stop (
        .i_clk  (master_clock),
        .i_rst_n(reset_n),
        .i_btn  (btn_start_stop),
        .o_press(w_ss_raw)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_db_clear (
        .i_clk  (master_clock),
        .i_rst_n(reset_n),
        .i_btn  (btn_clear),
        .o_press(w_clr_raw)
    );

`ifdef STOPWATCH_LAP_EN
    logic r_lap_latch;
    logic r_display_frozen;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_db_lap (
        .i_clk  (master_clock),
        .i_rst_n(reset_n),
        .i_btn  (btn_lap),
        .o_press(w_lap_raw)
    );

    // Lap outputs: split pulse and frozen-display select.
    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lap_latch      <= 1'b0;
            r_display_frozen <= 1'b0;
        end else begin
            r_lap_latch      <= w_lap_nxt;
            r_display_frozen <= (w_state_nxt == ST_LAP_HOLD);
        end
    end

    assign lap_latch      = r_lap_latch;
    assign display_frozen = r_display_frozen;
`else
    logic w_lap_unused;

    assign w_lap_raw      = 1'b0;
    assign w_lap_unused   = btn_lap ^ w_lap_nxt;
    assign lap_latch      = 1'b0;
    assign display_frozen = 1'b0;
`endif

    // Enable masks all events; clear outranks start/stop, which outranks lap,
    // and a losing event in the same cycle is dropped.
    assign w_ev_clr = enable & w_clr_raw;
    assign w_ev_ss  = enable & w_ss_raw & ~w_clr_raw;
    assign w_ev_lap = enable & w_lap_raw & ~w_clr_raw & ~w_ss_raw;

    // Next-state and pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_clear_nxt = 1'b0;
        w_lap_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_clr) begin
                    w_clear_nxt = 1'b1;
                end else if (w_ev_ss) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (w_ev_ss) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_ev_lap) begin
                    w_state_nxt = ST_LAP_HOLD;
                    w_lap_nxt   = 1'b1;
                end
            end
            ST_LAP_HOLD: begin
                // Clear here only unfreezes the display; counters keep going.
                if (w_ev_clr) begin
                    w_state_nxt = ST_RUNNING;
                end else if (w_ev_ss) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_ev_lap) begin
                    w_lap_nxt = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (w_ev_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_clear_nxt = 1'b1;
                end else if (w_ev_ss) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and the always-present registered outputs.
    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_count_en    <= 1'b0;
            r_clear_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count_en    <= enable & is_counting(w_state_nxt);
            r_clear_pulse <= w_clear_nxt;
        end
    end

    assign state       = r_state;
    assign count_en    = r_count_en;
    assign clear_pulse = r_clear_pulse;

endmodule
